hdma_xfer: RTL and testbench
============================

# hdma_xfer

Memory-side responder for the GBC HDMA/GDMA engine. It services the `hdma_rd` request stream from the HDMA register block: reads each source byte from the system bus and writes it to VRAM at the target address. It sits between the HDMA register block, the CPU bus multiplexer and the VRAM write port. While a transfer or a pending write is outstanding, it holds the CPU in a stall.

## Interface
Parameters:
- FIFO_DEPTH, 2: byte buffer depth between bus read and VRAM write; power of two, ≥2.
- SLOT_LEN, 4: clocks per source byte produced by the initiator (address advances every SLOT_LEN clocks).

Ports:
- clk  in  1  system clock (8 MHz CPU clock domain).
- reset_n  in  1  asynchronous, active-low reset.
- hdma_rd  in  1  transfer request level from the HDMA register block.
- hdma_source_addr  in  16  current source byte address.
- hdma_target_addr  in  16  current target address; bits [15:13] are always 3'b100.
- bus_addr  out  16  system bus read address.
- bus_rd  out  1  one-clock read strobe.
- bus_din  in  8  read data, valid one clock after bus_rd.
- vram_busy  in  1  VRAM not writable (PPU mode 3).
- vram_addr  out  13  VRAM byte address (target[12:0]).
- vram_wr  out  1  one-clock write strobe.
- vram_dout  out  8  write data.
- cpu_stall  out  1  halt the CPU.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.

## Operation
- New-byte detect: a new byte is detected on the rising edge of hdma_rd, or while hdma_rd=1 when hdma_source_addr differs from the last latched source address. On detect, latch the source and target addresses.
- Read FSM states: IDLE, REQ, CAPT.
  - IDLE→REQ on new-byte detect.
  - REQ: bus_addr is the latched source address; bus_rd=1 for exactly one clock; next state is CAPT.
  - CAPT: push {target[12:0], bus_din} into the FIFO.
    - If another new byte has already been detected, go to REQ; otherwise go to IDLE.
  - A detect that occurs during REQ or CAPT is queued as a single pending flag. Latches are 1 deep.
- Write side runs independently of the read FSM.
  - When the FIFO is not empty and vram_busy=0: pop, drive vram_addr/vram_dout, and assert vram_wr for one clock.
  - vram_busy=1 blocks the pop. Data is held and never dropped at the write side.
- A push to a full FIFO (with no simultaneous pop) drops the byte and sets overrun. A push and a pop in the same cycle are both accepted, even when the FIFO is full.
- overrun clears on the next rising edge of hdma_rd.
- cpu_stall = hdma_rd | (FSM≠IDLE) | pending | !fifo_empty.
- hdma_rd falling mid-byte: the in-flight read completes and is written. A pending detect that has not yet issued REQ is discarded.

## Timing
- Reset values:
  - All outputs 0.
  - bus_addr = 16'h0000, vram_addr = 13'h0000.
  - FSM = IDLE, FIFO empty, last source address = 16'hFFFF.
- Latency:
  - Detect clock → bus_rd: 1 clock.
  - bus_rd → FIFO push: 1 clock.
  - Push → vram_wr: 1 clock if vram_busy=0.
  - Total: 3 clocks from detect to vram_wr.
- Throughput: one byte per SLOT_LEN=4 clocks is sustained with no stalls. Minimum byte spacing is 2 clocks.
- cpu_stall asserts combinationally with hdma_rd. It deasserts in the clock after the last vram_wr.
- An asynchronous reset mid-transfer clears the FIFO, the FSM and overrun immediately. Buffered bytes are lost.

## Configuration
- HDMA_XFER_STATS_EN defined:
  - Adds output `byte_count` [15:0]: the number of vram_wr strobes since the last rising edge of hdma_rd.
  - Resets to 0.
  - Saturates at 16'hFFFF.
- Not defined: no port, no counter logic.

## Structure
- Shared package hdma_pkg holds:
  - FSM state enum {IDLE, REQ, CAPT}.
  - SLOT_LEN and FIFO_DEPTH defaults.
  - VRAM_BASE = 16'h8000.
  - FIFO entry width (21 bits: 13 address + 8 data).
- One sub-module: hdma_xfer_fifo, a synchronous FIFO parameterised by depth and width.
  - Outputs full/empty.
  - Same-cycle push+pop allowed when full.

## Test plan
- Single byte:
  - Stimulus: hdma_rd rises with src 16'h2040, tgt 16'h8200, bus_din 8'hA5.
  - Response: bus_rd at +1 with bus_addr 16'h2040; vram_wr at +3 with vram_addr 13'h0200, vram_dout 8'hA5; cpu_stall falls at +4.
- 32-byte GDMA burst:
  - Stimulus: address advances every 4 clocks, src 16'h2040..16'h205F.
  - Response: 32 vram_wr strobes with tgt 13'h0200..13'h021F in order; data matches; overrun=0; byte_count=32 with STATS_EN.
- vram_busy stall:
  - Stimulus: hold vram_busy=1 for 6 clocks during a 2-byte burst.
  - Response: no vram_wr while busy; both bytes written in order after release; cpu_stall held throughout.
- Overrun:
  - Stimulus: vram_busy=1 while 4 bytes arrive, FIFO_DEPTH=2.
  - Response: first 2 bytes written after release; overrun=1.
  - Then: next hdma_rd rising edge → overrun=0.
- Early stop:
  - Stimulus: hdma_rd falls one clock after a detect.
  - Response: that byte is still read and written; no further bus_rd.
- Reset mid-transfer:
  - Stimulus: assert reset_n=0 with 2 bytes buffered.
  - Response: all outputs 0 immediately; no vram_wr after release.

Source files
------------

// File: rtl/hdma_pkg.sv
// Shared types and defaults for the HDMA memory-side responder.
package hdma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } rd_state_e;

  localparam int unsigned SLOT_LEN_DEF   = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 2;
  localparam logic [15:0] VRAM_BASE      = 16'h8000;
  localparam int unsigned VADDR_W        = 13;
  localparam int unsigned ENTRY_W        = VADDR_W + 8;

endpackage

// File: rtl/hdma_xfer_fifo.sv
// Small synchronous FIFO between the bus-read side and the VRAM write port.
// A push to a full FIFO is accepted only when a pop happens in the same cycle.
module hdma_xfer_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hdma_xfer.sv
// HDMA/GDMA memory-side responder: bus read -> FIFO -> VRAM write, with CPU stall.
// Optional HDMA_XFER_STATS_EN adds a saturating byte_count of VRAM writes per request.
module hdma_xfer
  import hdma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned SLOT_LEN   = SLOT_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hdma_rd,
  input  logic [15:0] hdma_source_addr,
  input  logic [15:0] hdma_target_addr,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_din,
  input  logic        vram_busy,
  output logic [12:0] vram_addr,
  output logic        vram_wr,
  output logic [7:0]  vram_dout,
  output logic        cpu_stall,
  output logic        overrun
`ifdef HDMA_XFER_STATS_EN
  ,
  output logic [15:0] byte_count
`endif
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (SLOT_LEN < 2) begin : g_bad_slot
    $error("SLOT_LEN must be >= 2");
  end

  rd_state_e            state_q, state_d;
  logic                 rd_q;
  logic [15:0]          last_src_q;
  logic                 pend_q, pend_d;
  logic [15:0]          pend_src_q, pend_src_d;
  logic [VADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic [15:0]          req_src_q, req_src_d;
  logic [VADDR_W-1:0]   req_tgt_q, req_tgt_d;
  logic                 overrun_q, overrun_d;
  logic                 detect, rise;
  logic                 fifo_push, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic                 unused_tgt_hi;

  assign unused_tgt_hi = ^hdma_target_addr[15:13];

  assign rise   = hdma_rd & ~rd_q;
  assign detect = hdma_rd & (~rd_q | (hdma_source_addr != last_src_q));

  // A queued detect only survives while the request level stays high.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q & hdma_rd;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    req_src_d  = req_src_q;
    req_tgt_d  = req_tgt_q;
    fifo_push  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (detect) begin
          state_d   = REQ;
          req_src_d = hdma_source_addr;
          req_tgt_d = hdma_target_addr[VADDR_W-1:0];
        end
      end
      REQ: begin
        state_d = CAPT;
        if (detect) begin
          pend_d     = 1'b1;
          pend_src_d = hdma_source_addr;
          pend_tgt_d = hdma_target_addr[VADDR_W-1:0];
        end
      end
      CAPT: begin
        fifo_push = 1'b1;
        if (pend_q && hdma_rd) begin
          state_d   = REQ;
          req_src_d = pend_src_q;
          req_tgt_d = pend_tgt_q;
          pend_d    = detect;
          if (detect) begin
            pend_src_d = hdma_source_addr;
            pend_tgt_d = hdma_target_addr[VADDR_W-1:0];
          end
        end else if (detect) begin
          state_d   = REQ;
          req_src_d = hdma_source_addr;
          req_tgt_d = hdma_target_addr[VADDR_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overrun_d = rise ? 1'b0 : overrun_q;
    if (fifo_push && fifo_full && !vram_wr) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      last_src_q <= 16'hFFFF;
      pend_q     <= 1'b0;
      pend_src_q <= '0;
      pend_tgt_q <= '0;
      req_src_q  <= '0;
      req_tgt_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= hdma_rd;
      last_src_q <= detect ? hdma_source_addr : last_src_q;
      pend_q     <= pend_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
      req_src_q  <= req_src_d;
      req_tgt_q  <= req_tgt_d;
      overrun_q  <= overrun_d;
    end
  end

  hdma_xfer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({req_tgt_q, bus_din}),
    .pop     (vram_wr),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus_addr  = req_src_q;
  assign bus_rd    = (state_q == REQ);
  assign vram_wr   = ~fifo_empty & ~vram_busy;
  assign vram_addr = vram_wr ? fifo_rdata[ENTRY_W-1:8] : '0;
  assign vram_dout = vram_wr ? fifo_rdata[7:0] : '0;
  assign cpu_stall = hdma_rd | (state_q != IDLE) | pend_q | ~fifo_empty;
  assign overrun   = overrun_q;

`ifdef HDMA_XFER_STATS_EN
  logic [15:0] byte_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_count_q <= '0;
    end else if (rise) begin
      byte_count_q <= {15'd0, vram_wr};
    end else if (vram_wr && byte_count_q != 16'hFFFF) begin
      byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_hdma_xfer.sv
// Directed-plus-random bench for hdma_xfer against a byte-list reference model.
module tb_hdma_xfer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hdma_rd;
  logic [15:0] src;
  logic [15:0] tgt;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic [7:0]  bus_din = 8'h00;
  logic        vram_busy;
  logic [12:0] vram_addr;
  logic        vram_wr;
  logic [7:0]  vram_dout;
  logic        cpu_stall;
  logic        overrun;
`ifdef HDMA_XFER_STATS_EN
  logic [15:0] byte_count;
`endif

  hdma_xfer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .hdma_rd          (hdma_rd),
    .hdma_source_addr (src),
    .hdma_target_addr (tgt),
    .bus_addr         (bus_addr),
    .bus_rd           (bus_rd),
    .bus_din          (bus_din),
    .vram_busy        (vram_busy),
    .vram_addr        (vram_addr),
    .vram_wr          (vram_wr),
    .vram_dout        (vram_dout),
    .cpu_stall        (cpu_stall),
    .overrun          (overrun)
`ifdef HDMA_XFER_STATS_EN
    ,
    .byte_count       (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int n_wr   = 0;
  int n_exp_wr = 0;

  logic [7:0]  mem [256];
  logic [15:0] src_q [$];
  logic [20:0] wr_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic present(input logic [15:0] s, input logic [15:0] t, input bit keep);
    hdma_rd = 1'b1;
    src     = s;
    tgt     = t;
    src_q.push_back(s);
    if (keep) begin
      wr_q.push_back({t[12:0], mem[s[7:0]]});
      n_exp_wr++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_addr"},  32'(bus_addr),  0);
    chk({tag, "_bus_rd"},    32'(bus_rd),    0);
    chk({tag, "_vram_addr"}, 32'(vram_addr), 0);
    chk({tag, "_vram_wr"},   32'(vram_wr),   0);
    chk({tag, "_vram_dout"}, 32'(vram_dout), 0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 0);
    chk({tag, "_overrun"},   32'(overrun),   0);
  endtask

  // Bus slave + VRAM scoreboard.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus_rd) begin
        chk("bus_rd_expected", 32'(src_q.size() != 0), 1);
        if (src_q.size() != 0) chk("bus_addr", 32'(bus_addr), 32'(src_q.pop_front()));
        bus_din = mem[bus_addr[7:0]];
      end
      if (vram_wr) begin
        logic [20:0] e;
        n_wr++;
        chk("wr_while_busy", 32'(vram_busy), 0);
        chk("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("vram_addr", 32'(vram_addr), 32'(e[20:8]));
          chk("vram_dout", 32'(vram_dout), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    int          n_rb;
    logic [15:0] sbase;
    int          wr_mark;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h40] = 8'hA5;
    reset_n   = 1'b0;
    hdma_rd   = 1'b0;
    src       = 16'h0000;
    tgt       = 16'h8000;
    vram_busy = 1'b0;
    #1;
    chk_all_zero("reset");
`ifdef HDMA_XFER_STATS_EN
    chk("reset_byte_count", 32'(byte_count), 0);
`endif
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // single byte, exact latency
    tick(); present(16'h2040, 16'h8200, 1'b1);
    smp(); chk("single_stall_comb", 32'(cpu_stall), 1); chk("single_c0_bus_rd", 32'(bus_rd), 0);
    tick(); smp(); chk("single_c1_bus_rd", 32'(bus_rd), 1); chk("single_c1_bus_addr", 32'(bus_addr), 32'h2040);
    tick(); hdma_rd = 1'b0;
    smp(); chk("single_c2_vram_wr", 32'(vram_wr), 0);
    tick(); smp();
    chk("single_c3_vram_wr", 32'(vram_wr), 1);
    chk("single_c3_vram_addr", 32'(vram_addr), 32'h0200);
    chk("single_c3_vram_dout", 32'(vram_dout), 32'hA5);
    chk("single_c3_stall", 32'(cpu_stall), 1);
    tick(); smp(); chk("single_c4_stall", 32'(cpu_stall), 0); chk("single_c4_vram_wr", 32'(vram_wr), 0);
    repeat (3) tick();

    // 32-byte GDMA burst, one byte per 4 clocks, random short busy pulses
    wr_mark = n_wr;
    for (int i = 0; i < 32; i++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        if (c == 0) present(16'h2040 + 16'(i), 16'h8200 + 16'(i), 1'b1);
        vram_busy = (c < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    tick(); hdma_rd = 1'b0; vram_busy = 1'b0;
    repeat (4) tick();
    smp();
    chk("burst_writes", 32'(n_wr - wr_mark), 32);
    chk("burst_overrun", 32'(overrun), 0);
`ifdef HDMA_XFER_STATS_EN
    chk("burst_byte_count", 32'(byte_count), 32);
`endif

    // random burst at minimum 2-clock spacing
    n_rb  = $urandom_range(4, 10);
    sbase = 16'h3000 | 16'($urandom_range(0, 127));
    wr_mark = n_wr;
    for (int i = 0; i < n_rb; i++) begin
      tick(); present(sbase + 16'(i), 16'h8000 | 16'($urandom_range(0, 8191)), 1'b1);
      tick();
    end
    tick(); hdma_rd = 1'b0;
    repeat (5) tick();
    smp();
    chk("fast_writes", 32'(n_wr - wr_mark), 32'(n_rb));
    chk("fast_stall_idle", 32'(cpu_stall), 0);

    // vram_busy held 6 clocks during a 2-byte burst
    tick(); present(16'h2100, 16'h8300, 1'b1); vram_busy = 1'b1;
    smp(); chk("busy_c0_vram_wr", 32'(vram_wr), 0);
    for (int c = 1; c < 6; c++) begin
      tick();
      if (c == 4) present(16'h2101, 16'h8301, 1'b1);
      smp(); chk("busy_vram_wr", 32'(vram_wr), 0); chk("busy_stall", 32'(cpu_stall), 1);
    end
    tick(); vram_busy = 1'b0; hdma_rd = 1'b0;
    smp(); chk("busy_rel1_vram_wr", 32'(vram_wr), 1); chk("busy_rel1_stall", 32'(cpu_stall), 1);
    tick(); smp(); chk("busy_rel2_vram_wr", 32'(vram_wr), 1);
    tick(); smp(); chk("busy_done_stall", 32'(cpu_stall), 0);
    repeat (2) tick();

    // overrun: 4 bytes at 2-clock spacing into a blocked 2-deep FIFO
    vram_busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      case (c)
        0: present(16'h2200, 16'h8400, 1'b1);
        2: present(16'h2201, 16'h8401, 1'b1);
        4: present(16'h2202, 16'h8402, 1'b0);
        6: present(16'h2203, 16'h8403, 1'b0);
        8: hdma_rd = 1'b0;
        default: ;
      endcase
    end
    smp(); chk("ovr_set", 32'(overrun), 1); chk("ovr_blocked", 32'(vram_wr), 0);
    tick(); vram_busy = 1'b0;
    smp(); chk("ovr_rel1_vram_wr", 32'(vram_wr), 1);
    tick(); smp(); chk("ovr_rel2_vram_wr", 32'(vram_wr), 1);
    tick(); smp(); chk("ovr_rel3_vram_wr", 32'(vram_wr), 0); chk("ovr_sticky", 32'(overrun), 1);
    tick(); present(16'h2300, 16'h8500, 1'b1);
    smp(); chk("ovr_before_clear", 32'(overrun), 1);
    tick(); hdma_rd = 1'b0;
    smp(); chk("ovr_cleared", 32'(overrun), 0);
    repeat (5) tick();

    // early stop: a second detect queued in REQ is dropped when hdma_rd falls
    tick(); present(16'h2400, 16'h8600, 1'b1);
    tick(); src = 16'h2401; tgt = 16'h8601;
    smp(); chk("early_bus_rd", 32'(bus_rd), 1);
    tick(); hdma_rd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      smp(); chk("early_no_bus_rd", 32'(bus_rd), 0);
      tick();
    end
    smp(); chk("early_written", 32'(wr_q.size()), 0); chk("early_stall", 32'(cpu_stall), 0);

    // reset with two bytes buffered behind vram_busy
    vram_busy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) present(16'h2500, 16'h8700, 1'b0);
      if (c == 4) present(16'h2501, 16'h8701, 1'b0);
    end
    hdma_rd = 1'b0;
    #2;
    chk("rst_pre_stall", 32'(cpu_stall), 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(); tick();
    reset_n   = 1'b1;
    vram_busy = 1'b0;
    for (int c = 0; c < 8; c++) begin
      smp(); chk("post_reset_vram_wr", 32'(vram_wr), 0);
      tick();
    end

    chk("final_src_q_empty", 32'(src_q.size()), 0);
    chk("final_wr_q_empty", 32'(wr_q.size()), 0);
    chk("final_write_count", 32'(n_wr), 32'(n_exp_wr));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
